// File: rtl/mem_arbiter.sv
// mem_arbiter: two-requester (instruction cache / data cache) arbiter for one
// shared physical-memory port. Round-robin on ties, one grant at a time, one
// IDLE cycle between transactions.
//
// Ports
//   clk, reset                 rising-edge clock, synchronous active-high reset
//   i_read/i_write/i_address/i_wdata -> i_resp/i_rdata   instruction-side port
//   d_read/d_write/d_address/d_wdata -> d_resp/d_rdata   data-side port
//   pmem_read/pmem_write/pmem_address/pmem_wdata -> pmem_resp/pmem_rdata
//                              shared memory port (request out, completion in)
module mem_arbiter #(
   localparam int unsigned ADDR_W = 16,
   localparam int unsigned LINE_W = 128
) (
   input  logic              clk,
   input  logic              reset,

   input  logic              i_read,
   input  logic              i_write,
   input  logic [ADDR_W-1:0] i_address,
   input  logic [LINE_W-1:0] i_wdata,
   output logic              i_resp,
   output logic [LINE_W-1:0] i_rdata,

   input  logic              d_read,
   input  logic              d_write,
   input  logic [ADDR_W-1:0] d_address,
   input  logic [LINE_W-1:0] d_wdata,
   output logic              d_resp,
   output logic [LINE_W-1:0] d_rdata,

   output logic              pmem_read,
   output logic              pmem_write,
   output logic [ADDR_W-1:0] pmem_address,
   output logic [LINE_W-1:0] pmem_wdata,
   input  logic              pmem_resp,
   input  logic [LINE_W-1:0] pmem_rdata
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      GRANT_I = 2'd1,
      GRANT_D = 2'd2
   } state_e;

   state_e state_q, state_d;
   // Side that received the most recent grant: 0 = I, 1 = D.
   logic   last_grant_q, last_grant_d;

   logic   i_pend, d_pend;

   assign i_pend = i_read | i_write;
   assign d_pend = d_read | d_write;

   // State register; reset leaves last_grant = D so the first tie goes to I.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= IDLE;
         last_grant_q <= 1'b1;
      end else begin
         state_q      <= state_d;
         last_grant_q <= last_grant_d;
      end
   end

   // Next-state: arbitrate only from IDLE, leave a grant only on pmem_resp.
   always_comb begin
      state_d      = state_q;
      last_grant_d = last_grant_q;
      case (state_q)
         IDLE: begin
            // On a tie I wins only if D was granted last.
            if (i_pend && (!d_pend || last_grant_q)) begin
               state_d      = GRANT_I;
               last_grant_d = 1'b0;
            end else if (d_pend) begin
               state_d      = GRANT_D;
               last_grant_d = 1'b1;
            end
         end
         GRANT_I, GRANT_D: begin
            if (pmem_resp) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Output steering; forced quiet while reset is asserted so an abandoned
   // transaction produces no request and no completion.
   always_comb begin
      pmem_read    = 1'b0;
      pmem_write   = 1'b0;
      pmem_address = '0;
      pmem_wdata   = '0;
      i_resp       = 1'b0;
      d_resp       = 1'b0;
      if (!reset) begin
         case (state_q)
            GRANT_I: begin
               pmem_read    = i_read;
               pmem_write   = i_write;
               pmem_address = i_address;
               pmem_wdata   = i_wdata;
               i_resp       = pmem_resp;
            end
            GRANT_D: begin
               pmem_read    = d_read;
               pmem_write   = d_write;
               pmem_address = d_address;
               pmem_wdata   = d_wdata;
               d_resp       = pmem_resp;
            end
            default: ;
         endcase
      end
   end

   // Read data is broadcast; each side qualifies it with its own resp.
   assign i_rdata = pmem_rdata;
   assign d_rdata = pmem_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Testbench for mem_arbiter: directed vector table, hand-written corner
// sequences, then randomized traffic against a transaction-level model.
module tb_mem_arbiter;

   localparam logic [127:0] I_W = 128'h1111_2222_3333_4444_5555_6666_7777_8888;
   localparam logic [127:0] D_W = 128'hAAAA_AAAA_AAAA_AAAA_AAAA_AAAA_AAAA_AAAA;
   localparam logic [127:0] RD  = 128'h0123_4567_89AB_CDEF_0123_4567_89AB_CDEF;

   logic         clk;
   logic         reset;
   logic         i_read, i_write, d_read, d_write;
   logic [15:0]  i_address, d_address;
   logic [127:0] i_wdata, d_wdata;
   logic         i_resp, d_resp;
   logic [127:0] i_rdata, d_rdata;
   logic         pmem_read, pmem_write;
   logic [15:0]  pmem_address;
   logic [127:0] pmem_wdata;
   logic         pmem_resp;
   logic [127:0] pmem_rdata;

   mem_arbiter dut (
      .clk(clk), .reset(reset),
      .i_read(i_read), .i_write(i_write), .i_address(i_address), .i_wdata(i_wdata),
      .i_resp(i_resp), .i_rdata(i_rdata),
      .d_read(d_read), .d_write(d_write), .d_address(d_address), .d_wdata(d_wdata),
      .d_resp(d_resp), .d_rdata(d_rdata),
      .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_address(pmem_address),
      .pmem_wdata(pmem_wdata), .pmem_resp(pmem_resp), .pmem_rdata(pmem_rdata)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   typedef struct packed {
      logic         pr;
      logic         pw;
      logic [15:0]  addr;
      logic [127:0] wd;
      logic         ir;
      logic         dr;
      logic [127:0] ird;
      logic [127:0] drd;
   } outs_t;

   // One cycle: applied inputs and the outputs required during that cycle.
   // ewsel: 0 = no write line, 1 = I line, 2 = D line on pmem_wdata.
   typedef struct {
      logic        rst, ir, iw, dr, dw, presp;
      logic [15:0] ia, da;
      logic        er, ew;
      logic [15:0] ea;
      logic [1:0]  ewsel;
      logic        eir, edr;
   } row_t;

   int n_vec = 0;
   int n_bad = 0;

   // Reference model: which side currently owns memory (0 none, 1 I, 2 D)
   // and which side was served most recently (ties go to the other one).
   int owner;
   int last_served;

   task automatic check(input int tag, input outs_t exp);
      outs_t got;
      got = {pmem_read, pmem_write, pmem_address, pmem_wdata,
             i_resp, d_resp, i_rdata, d_rdata};
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL vec%0d outputs got=%h required=%h", tag, got, exp);
      end
   endtask

   function automatic outs_t model_out();
      outs_t o;
      o = '0;
      o.ird = pmem_rdata;
      o.drd = pmem_rdata;
      if (!reset && owner == 1) begin
         o.pr = i_read;  o.pw = i_write; o.addr = i_address; o.wd = i_wdata;
         o.ir = pmem_resp;
      end else if (!reset && owner == 2) begin
         o.pr = d_read;  o.pw = d_write; o.addr = d_address; o.wd = d_wdata;
         o.dr = pmem_resp;
      end
      return o;
   endfunction

   task automatic model_edge();
      bit want_i, want_d;
      want_i = i_read || i_write;
      want_d = d_read || d_write;
      if (reset) begin
         owner = 0;
         last_served = 2;
      end else if (owner == 0) begin
         if (want_i && want_d) owner = (last_served == 1) ? 2 : 1;
         else if (want_i)      owner = 1;
         else if (want_d)      owner = 2;
         if (owner != 0) last_served = owner;
      end else if (pmem_resp) begin
         owner = 0;
      end
   endtask

   // Inputs are already applied; check mid-cycle, then advance one edge.
   task automatic cycle(input int tag, input bit use_model, input outs_t texp);
      #2;
      check(tag, use_model ? model_out() : texp);
      @(posedge clk);
      model_edge();
      #1;
   endtask

   task automatic run_row(input int tag, input row_t r);
      outs_t e;
      reset = r.rst; pmem_resp = r.presp;
      i_read = r.ir; i_write = r.iw; i_address = r.ia; i_wdata = I_W;
      d_read = r.dr; d_write = r.dw; d_address = r.da; d_wdata = D_W;
      pmem_rdata = RD;
      e = '0;
      e.pr = r.er; e.pw = r.ew; e.addr = r.ea;
      e.wd = (r.ewsel == 2'd1) ? I_W : (r.ewsel == 2'd2) ? D_W : '0;
      e.ir = r.eir; e.dr = r.edr;
      e.ird = RD; e.drd = RD;
      cycle(tag, 1'b0, e);
   endtask

   row_t tbl[$];

   initial begin
      owner = 0;
      last_served = 2;
      reset = 1'b1; pmem_resp = 1'b0; pmem_rdata = RD;
      i_read = 1'b0; i_write = 1'b0; i_address = '0; i_wdata = I_W;
      d_read = 1'b0; d_write = 1'b0; d_address = '0; d_wdata = D_W;
      @(posedge clk);
      #1;

      //                rst ir iw dr dw rs  ia        da        er ew ea        ws eir edr
      // Reset, then single I read at 0x0040 completed after 3 cycles.
      tbl.push_back(row_t'{1, 0, 0, 0, 0, 0, 16'h0000, 16'h0000, 0, 0, 16'h0000, 0, 0, 0});
      tbl.push_back(row_t'{1, 1, 0, 0, 0, 1, 16'h0040, 16'h0000, 0, 0, 16'h0000, 0, 0, 0});
      tbl.push_back(row_t'{0, 1, 0, 0, 0, 0, 16'h0040, 16'h0000, 0, 0, 16'h0000, 0, 0, 0});
      tbl.push_back(row_t'{0, 1, 0, 0, 0, 0, 16'h0040, 16'h0000, 1, 0, 16'h0040, 1, 0, 0});
      tbl.push_back(row_t'{0, 1, 0, 0, 0, 0, 16'h0040, 16'h0000, 1, 0, 16'h0040, 1, 0, 0});
      tbl.push_back(row_t'{0, 1, 0, 0, 0, 1, 16'h0040, 16'h0000, 1, 0, 16'h0040, 1, 1, 0});
      tbl.push_back(row_t'{0, 0, 0, 0, 0, 0, 16'h0040, 16'h0000, 0, 0, 16'h0000, 0, 0, 0});
      // Reset, then simultaneous I read / D write, both held: I, gap, D, gap, I.
      tbl.push_back(row_t'{1, 0, 0, 0, 0, 0, 16'h0100, 16'h2000, 0, 0, 16'h0000, 0, 0, 0});
      tbl.push_back(row_t'{0, 1, 0, 0, 1, 0, 16'h0100, 16'h2000, 0, 0, 16'h0000, 0, 0, 0});
      tbl.push_back(row_t'{0, 1, 0, 0, 1, 0, 16'h0100, 16'h2000, 1, 0, 16'h0100, 1, 0, 0});
      tbl.push_back(row_t'{0, 1, 0, 0, 1, 1, 16'h0100, 16'h2000, 1, 0, 16'h0100, 1, 1, 0});
      tbl.push_back(row_t'{0, 1, 0, 0, 1, 0, 16'h0100, 16'h2000, 0, 0, 16'h0000, 0, 0, 0});
      tbl.push_back(row_t'{0, 1, 0, 0, 1, 0, 16'h0100, 16'h2000, 0, 1, 16'h2000, 2, 0, 0});
      tbl.push_back(row_t'{0, 1, 0, 0, 1, 1, 16'h0100, 16'h2000, 0, 1, 16'h2000, 2, 0, 1});
      tbl.push_back(row_t'{0, 1, 0, 0, 1, 0, 16'h0100, 16'h2000, 0, 0, 16'h0000, 0, 0, 0});
      tbl.push_back(row_t'{0, 1, 0, 0, 1, 0, 16'h0100, 16'h2000, 1, 0, 16'h0100, 1, 0, 0});
      tbl.push_back(row_t'{0, 1, 0, 0, 1, 1, 16'h0100, 16'h2000, 1, 0, 16'h0100, 1, 1, 0});
      // Stray response in IDLE is ignored, state stays IDLE.
      tbl.push_back(row_t'{0, 0, 0, 0, 0, 1, 16'h0100, 16'h2000, 0, 0, 16'h0000, 0, 0, 0});
      tbl.push_back(row_t'{0, 0, 0, 0, 0, 0, 16'h0100, 16'h2000, 0, 0, 16'h0000, 0, 0, 0});

      foreach (tbl[k]) run_row(k, tbl[k]);

      // Reset in the 2nd cycle of GRANT_D, late pmem_resp, then a normal I read.
      run_row(100, row_t'{0, 0, 0, 0, 1, 0, 16'h0000, 16'h2000, 0, 0, 16'h0000, 0, 0, 0});
      run_row(101, row_t'{0, 0, 0, 0, 1, 0, 16'h0000, 16'h2000, 0, 1, 16'h2000, 2, 0, 0});
      run_row(102, row_t'{1, 0, 0, 0, 1, 0, 16'h0000, 16'h2000, 0, 0, 16'h0000, 0, 0, 0});
      run_row(103, row_t'{0, 0, 0, 0, 0, 1, 16'h0000, 16'h2000, 0, 0, 16'h0000, 0, 0, 0});
      run_row(104, row_t'{0, 1, 0, 0, 0, 0, 16'h0040, 16'h2000, 0, 0, 16'h0000, 0, 0, 0});
      run_row(105, row_t'{0, 1, 0, 0, 0, 0, 16'h0040, 16'h2000, 1, 0, 16'h0040, 1, 0, 0});
      run_row(106, row_t'{0, 1, 0, 0, 0, 1, 16'h0040, 16'h2000, 1, 0, 16'h0040, 1, 1, 0});
      run_row(107, row_t'{0, 0, 0, 0, 0, 0, 16'h0040, 16'h2000, 0, 0, 16'h0000, 0, 0, 0});

      // D read dropped mid-grant: grant held until pmem_resp, single d_resp.
      run_row(110, row_t'{0, 0, 0, 1, 0, 0, 16'h0000, 16'h1234, 0, 0, 16'h0000, 0, 0, 0});
      run_row(111, row_t'{0, 0, 0, 1, 0, 0, 16'h0000, 16'h1234, 1, 0, 16'h1234, 2, 0, 0});
      run_row(112, row_t'{0, 0, 0, 0, 0, 0, 16'h0000, 16'h1234, 0, 0, 16'h1234, 2, 0, 0});
      run_row(113, row_t'{0, 0, 0, 0, 0, 1, 16'h0000, 16'h1234, 0, 0, 16'h1234, 2, 0, 1});
      run_row(114, row_t'{0, 0, 0, 0, 0, 0, 16'h0000, 16'h1234, 0, 0, 16'h0000, 0, 0, 0});
      run_row(115, row_t'{0, 0, 0, 0, 0, 1, 16'h0000, 16'h1234, 0, 0, 16'h0000, 0, 0, 0});

      // Randomized traffic checked against the reference model.
      for (int c = 0; c < 600; c++) begin
         reset      = ($urandom_range(0, 49) == 0);
         i_read     = ($urandom_range(0, 2) == 0);
         i_write    = ($urandom_range(0, 5) == 0);
         d_read     = ($urandom_range(0, 2) == 0);
         d_write    = ($urandom_range(0, 5) == 0);
         i_address  = 16'($urandom);
         d_address  = 16'($urandom);
         i_wdata    = {$urandom, $urandom, $urandom, $urandom};
         d_wdata    = {$urandom, $urandom, $urandom, $urandom};
         pmem_resp  = ($urandom_range(0, 3) == 0);
         pmem_rdata = {$urandom, $urandom, $urandom, $urandom};
         cycle(1000 + c, 1'b1, '0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 i_read, i_write  input  1 each  instruction-cache line read/write request.
REQ-005 i_address  input  16 (lc3b_word)  instruction-side line address.
REQ-006 i_wdata  input  128 (lc3b_mem_data)  instruction-side write line.
REQ-007 i_resp  output  1  instruction-side completion pulse.
REQ-008 i_rdata  output  128  instruction-side read line.
REQ-009 d_read, d_write, d_address, d_wdata, d_resp, d_rdata: same directions and widths as the i_ ports, for the data cache.
REQ-010 pmem_read, pmem_write  output  1 each  shared physical-memory request.
REQ-011 pmem_address  output  16  shared address.
REQ-012 pmem_wdata  output  128  shared write line.
REQ-013 pmem_resp  input  1  memory completion pulse.
REQ-014 pmem_rdata  input  128  memory read line.

Function
REQ-015 The FSM SHALL have three states: IDLE, GRANT_I and GRANT_D, plus a 1-bit register last_grant (0 = I, 1 = D).
REQ-016 In IDLE, requester X is pending when X_read or X_write is 1.
- Only I pending: next state GRANT_I.
- Only D pending: next state GRANT_D.
- Neither pending: stay in IDLE.
REQ-017 When both requesters are pending in IDLE, the grant SHALL go to the side opposite last_grant (round-robin).
REQ-018 last_grant SHALL update on entry to a GRANT state.
REQ-019 Grant latency SHALL be one cycle: a request first sampled in IDLE at edge N SHALL drive pmem_* from cycle N+1.
REQ-020 pmem_* SHALL be 0 in IDLE.
REQ-021 In GRANT_X, pmem_read, pmem_write, pmem_address and pmem_wdata SHALL equal the X_ inputs combinationally.
REQ-022 In GRANT_X, X_resp SHALL equal pmem_resp, and the other side's resp SHALL be 0.
REQ-023 i_rdata and d_rdata SHALL both equal pmem_rdata at all times.
REQ-024 GRANT_X SHALL return to IDLE on the edge where pmem_resp = 1.
REQ-025 One IDLE cycle SHALL separate consecutive transactions, so there are no back-to-back grants.
REQ-026 A requester SHALL hold its request and operands stable until its resp.
REQ-027 If a granted requester drops its request before pmem_resp, the arbiter SHALL stay in GRANT_X until pmem_resp; no abort is supported.
REQ-028 pmem_resp while in IDLE SHALL be ignored: no resp to either side, no state change.
REQ-029 Read and write asserted together on one side SHALL be forwarded unchanged; it is illegal upstream and is not checked.
REQ-030 The ungranted side SHALL see resp = 0 for the whole transaction, and its pending request SHALL be serviced next.
REQ-031 Worst-case wait for a pending requester SHALL be one full opposite-side transaction plus 2 cycles (starvation-free).

Reset
REQ-032 While reset = 1 at a rising edge, the next state SHALL be IDLE and last_grant SHALL be 1, so the first tie goes to I.
REQ-033 During and after reset, all outputs SHALL be 0, except i_rdata/d_rdata, which follow pmem_rdata.
REQ-034 Reset asserted mid-transaction SHALL abandon it: IDLE next cycle, pmem_read/pmem_write deasserted, no resp generated.
REQ-035 A pmem_resp arriving after a reset abandon SHALL be ignored per REQ-028.

Verification
REQ-036 Single I read:
- Stimulus: i_read = 1, i_address = 0x0040; pmem_resp after 3 cycles with rdata = 0x0123...CDEF.
- Response: pmem_read = 1 with address 0x0040 from the cycle after the request; i_resp pulses for 1 cycle with i_rdata = the same line; d_resp stays 0.
REQ-037 Simultaneous requests after reset:
- Stimulus: i_read at 0x0100 and d_write at 0x2000 with wdata = 0xAAAA...; both held.
- Response: I is served first. After its resp, one IDLE cycle, then pmem_write = 1 with address 0x2000 and wdata = 0xAAAA...; d_resp only.
REQ-038 Round-robin tie:
- Stimulus: two consecutive ties after an I grant.
- Response: D, then I; no side is granted twice in a row while the other is pending.
REQ-039 Reset mid-transaction:
- Stimulus: reset in the 2nd cycle of GRANT_D, then pmem_resp = 1.
- Response: pmem_write = 0 next cycle; no d_resp; state IDLE; a following i_read is granted normally.
REQ-040 Stray response and request drop:
- Stimulus: pmem_resp = 1 in IDLE; then d_read drops mid-grant.
- Response: no resp is generated for the stray pulse; for the drop, the grant is held until pmem_resp, and d_resp pulses once.
